// File: rtl/mig_ui_port_bridge.sv
// mig_ui_port_bridge
//
// Bridges one client request port to the MIG 7-series user interface (UI).
// A request is captured in IDLE. In ISSUE, the command and write-data
// handshakes run independently until both are done. The bridge also counts
// reads that have been accepted but not yet returned. New requests are
// refused once that count reaches MAX_OUTSTANDING.
//
// Ports
//   clk, reset              UI clock; synchronous active-high reset
//   init_calib_complete     MIG calibration done; gates new accepts
//   bus_*                   client request (enable/addr/write/data/byte enables),
//                           bus_ready, and registered read return
//   app_en/app_cmd/app_addr MIG command channel (app_rdy handshake)
//   app_wdf_*               MIG write-data channel (app_wdf_rdy handshake)
//   app_rd_data*            MIG read return
//   rd_overflow_err         sticky: read data seen with no read outstanding

module mig_ui_port_bridge #(
    parameter int unsigned DATA_WIDTH      = 128,
    parameter int unsigned ADDR_WIDTH      = 24,
    parameter int unsigned APP_ADDR_WIDTH  = 28,
    parameter int unsigned APP_ADDR_SHIFT  = 3,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init_calib_complete,

    input  logic                      bus_enable,
    input  logic [ADDR_WIDTH-1:0]     bus_addr,
    input  logic                      bus_write,
    input  logic [DATA_WIDTH-1:0]     bus_write_data,
    input  logic [DATA_WIDTH/8-1:0]   bus_write_byte_enable,
    output logic                      bus_ready,
    output logic [DATA_WIDTH-1:0]     bus_read_data,
    output logic                      bus_read_data_valid,

    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    output logic                      app_en,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [2:0]                app_cmd,
    output logic [APP_ADDR_WIDTH-1:0] app_addr,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic [DATA_WIDTH-1:0]     app_rd_data,
    input  logic                      app_rd_data_valid,

    output logic                      rd_overflow_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0]  MAX_OUT  = 8'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_pend_q, cmd_pend_d;
    logic                    wdf_pend_q, wdf_pend_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic [7:0]              outstanding_q, outstanding_d;
    logic                    rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    accept;
    logic                    rd_accept;

    // This depends only on registered state and calibration. It never looks
    // at bus_enable or bus_write, so there is no combinational path from the
    // request back to bus_ready.
    assign bus_ready = (state_q == StIdle) && init_calib_complete &&
                       (outstanding_q < MAX_OUT);

    assign accept    = bus_enable && bus_ready;
    assign rd_accept = accept && !bus_write;

    always_comb begin
        state_d       = state_q;
        cmd_pend_d    = cmd_pend_q;
        wdf_pend_d    = wdf_pend_q;
        addr_d        = addr_q;
        write_d       = write_q;
        data_d        = data_q;
        be_d          = be_q;
        outstanding_d = outstanding_q;
        rd_err_d      = rd_err_q;
        rd_data_d     = app_rd_data;
        rd_valid_d    = app_rd_data_valid;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d     = bus_addr;
                    write_d    = bus_write;
                    data_d     = bus_write_data;
                    be_d       = bus_write_byte_enable;
                    cmd_pend_d = 1'b1;
                    wdf_pend_d = bus_write;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (cmd_pend_q && app_rdy) begin
                    cmd_pend_d = 1'b0;
                end
                if (wdf_pend_q && app_wdf_rdy) begin
                    wdf_pend_d = 1'b0;
                end
                // Leave on the edge that retires the last pending handshake.
                // This gives the next accept two cycles after the previous one.
                if (!cmd_pend_d && !wdf_pend_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // If a read is accepted on the same edge that a read returns, the
        // count does not change. A return with nothing outstanding leaves
        // the count at zero.
        if (rd_accept && !app_rd_data_valid) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (!rd_accept && app_rd_data_valid && (outstanding_q != 8'd0)) begin
            outstanding_d = outstanding_q - 8'd1;
        end

        if (app_rd_data_valid && (outstanding_q == 8'd0)) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cmd_pend_q    <= 1'b0;
            wdf_pend_q    <= 1'b0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            data_q        <= '0;
            be_q          <= '0;
            outstanding_q <= 8'd0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_pend_q    <= cmd_pend_d;
            wdf_pend_q    <= wdf_pend_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            data_q        <= data_d;
            be_q          <= be_d;
            outstanding_q <= outstanding_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // The captured registers only change on accept. While a pend flag is
    // set, the address and data driven to the MIG therefore stay stable.
    assign app_en              = cmd_pend_q;
    assign app_wdf_wren        = wdf_pend_q;
    assign app_wdf_end         = wdf_pend_q;
    assign app_cmd             = write_q ? 3'b000 : 3'b001;
    assign app_addr            = APP_ADDR_WIDTH'(addr_q) << APP_ADDR_SHIFT;
    assign app_wdf_data        = data_q;
    assign app_wdf_mask        = ~be_q;
    assign bus_read_data       = rd_data_q;
    assign bus_read_data_valid = rd_valid_q;
    assign rd_overflow_err     = rd_err_q;

endmodule

// File: tb/tb_mig_ui_port_bridge.sv
module tb_mig_ui_port_bridge;

    localparam int unsigned DW   = 128;
    localparam int unsigned AW   = 24;
    localparam int unsigned AAW  = 28;
    localparam int unsigned MAXO = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            init_calib_complete;
    logic            bus_enable;
    logic [AW-1:0]   bus_addr;
    logic            bus_write;
    logic [DW-1:0]   bus_write_data;
    logic [DW/8-1:0] bus_write_byte_enable;
    logic            bus_ready;
    logic [DW-1:0]   bus_read_data;
    logic            bus_read_data_valid;
    logic            app_rdy;
    logic            app_wdf_rdy;
    logic            app_en;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [2:0]      app_cmd;
    logic [AAW-1:0]  app_addr;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            rd_overflow_err;

    mig_ui_port_bridge #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .APP_ADDR_WIDTH  (AAW),
        .APP_ADDR_SHIFT  (3),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .init_calib_complete   (init_calib_complete),
        .bus_enable            (bus_enable),
        .bus_addr              (bus_addr),
        .bus_write             (bus_write),
        .bus_write_data        (bus_write_data),
        .bus_write_byte_enable (bus_write_byte_enable),
        .bus_ready             (bus_ready),
        .bus_read_data         (bus_read_data),
        .bus_read_data_valid   (bus_read_data_valid),
        .app_rdy               (app_rdy),
        .app_wdf_rdy           (app_wdf_rdy),
        .app_en                (app_en),
        .app_wdf_wren          (app_wdf_wren),
        .app_wdf_end           (app_wdf_end),
        .app_cmd               (app_cmd),
        .app_addr              (app_addr),
        .app_wdf_data          (app_wdf_data),
        .app_wdf_mask          (app_wdf_mask),
        .app_rd_data           (app_rd_data),
        .app_rd_data_valid     (app_rd_data_valid),
        .rd_overflow_err       (rd_overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a command and a write beat wait for their MIG handshake.
    typedef struct packed {
        logic [AAW-1:0] addr;
        logic [2:0]     cmd;
    } cmd_t;
    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] mask;
    } wdf_t;

    cmd_t          cmdq[$];
    wdf_t          wdfq[$];
    int            m_out;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] dbeef;
        cmd_t          c;
        wdf_t          w;
        logic          acc;
        logic          rd_acc;

        d1    = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        d2    = {32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C};
        dbeef = {4{32'hDEADBEEF}};

        reset = 1'b1; init_calib_complete = 1'b0;
        bus_enable = 1'b0; bus_addr = '0; bus_write = 1'b0;
        bus_write_data = '0; bus_write_byte_enable = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Uncalibrated: a held request must never be accepted.
        bus_enable = 1'b1; bus_write = 1'b1; bus_addr = 24'h000ABC;
        tick(); tick(); tick();
        chk("uncal_ready", bus_ready, 1'b0);
        chk("uncal_app_en", app_en, 1'b0);
        chk("uncal_wren", app_wdf_wren, 1'b0);
        chk("uncal_wend", app_wdf_end, 1'b0);
        chk("uncal_addr", app_addr, '0);
        chk("uncal_wdata", app_wdf_data, '0);
        chk("uncal_mask", app_wdf_mask, 16'hFFFF);
        chk("uncal_cmd", app_cmd, 3'b001);
        chk("uncal_rvalid", bus_read_data_valid, 1'b0);
        chk("uncal_rdata", bus_read_data, '0);
        chk("uncal_err", rd_overflow_err, 1'b0);
        bus_enable = 1'b0;

        // Basic write with both MIG channels ready.
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        #1;
        chk("cal_ready", bus_ready, 1'b1);
        bus_enable = 1'b1; bus_write = 1'b1; bus_addr = 24'h123456;
        bus_write_data = d1; bus_write_byte_enable = 16'h00FF;
        tick();
        bus_enable = 1'b0;
        chk("wr_app_en", app_en, 1'b1);
        chk("wr_wren", app_wdf_wren, 1'b1);
        chk("wr_wend", app_wdf_end, 1'b1);
        chk("wr_addr", app_addr, 28'h091A2B0);
        chk("wr_cmd", app_cmd, 3'b000);
        chk("wr_mask", app_wdf_mask, 16'hFF00);
        chk("wr_data", app_wdf_data, d1);
        chk("wr_busy", bus_ready, 1'b0);
        tick();
        chk("wr_app_en_1cyc", app_en, 1'b0);
        chk("wr_wren_1cyc", app_wdf_wren, 1'b0);
        chk("wr_ready_again", bus_ready, 1'b1);

        // Stalled write: cmd channel ready after 3 cycles, data channel after 5.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        bus_enable = 1'b1; bus_write = 1'b1; bus_addr = 24'hABCDEF;
        bus_write_data = d2; bus_write_byte_enable = 16'hF0F0;
        tick();
        bus_enable = 1'b0; bus_addr = '0; bus_write_data = '0; bus_write_byte_enable = '0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            app_rdy     = (cyc >= 3);
            app_wdf_rdy = (cyc >= 5);
            chk("stall_app_en", app_en, cyc <= 3);
            chk("stall_wren", app_wdf_wren, cyc <= 5);
            if (cyc <= 5) begin
                chk("stall_addr", app_addr, 28'h55E6F78);
                chk("stall_data", app_wdf_data, d2);
                chk("stall_mask", app_wdf_mask, 16'h0F0F);
            end
            chk("stall_ready", bus_ready, cyc == 6);
            tick();
        end

        // Two outstanding reads reach the limit of 2.
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        bus_enable = 1'b1; bus_write = 1'b0; bus_addr = 24'h000010;
        tick();
        bus_enable = 1'b0;
        chk("rd1_cmd", app_cmd, 3'b001);
        chk("rd1_app_en", app_en, 1'b1);
        chk("rd1_wren", app_wdf_wren, 1'b0);
        tick();
        chk("rd1_ready", bus_ready, 1'b1);
        bus_enable = 1'b1; bus_addr = 24'h000020;
        tick();
        bus_enable = 1'b0;
        tick();
        chk("rd2_limit", bus_ready, 1'b0);
        tick();
        chk("rd2_limit_hold", bus_ready, 1'b0);
        app_rd_data_valid = 1'b1; app_rd_data = dbeef;
        tick();
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        chk("ret_valid", bus_read_data_valid, 1'b1);
        chk("ret_data", bus_read_data, dbeef);
        chk("ret_ready", bus_ready, 1'b1);
        tick();
        chk("ret_valid_1cyc", bus_read_data_valid, 1'b0);

        // One read outstanding. An accept on the same edge as a return keeps it at 1.
        bus_enable = 1'b1; bus_write = 1'b0; bus_addr = 24'h000030;
        app_rd_data_valid = 1'b1; app_rd_data = d1;
        tick();
        bus_enable = 1'b0; app_rd_data_valid = 1'b0;
        tick();
        chk("same_ready", bus_ready, 1'b1);
        bus_enable = 1'b1; bus_addr = 24'h000040;
        tick();
        bus_enable = 1'b0;
        tick();
        chk("same_full", bus_ready, 1'b0);
        app_rd_data_valid = 1'b1;
        tick(); tick();
        app_rd_data_valid = 1'b0;
        tick();
        chk("drain_err", rd_overflow_err, 1'b0);
        chk("drain_ready", bus_ready, 1'b1);

        // A return with nothing outstanding sets a sticky error.
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        chk("ovf_set", rd_overflow_err, 1'b1);
        tick(); tick();
        chk("ovf_sticky", rd_overflow_err, 1'b1);
        do_reset();
        chk("ovf_cleared", rd_overflow_err, 1'b0);

        // Reset while a request is in flight abandons it.
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        bus_enable = 1'b1; bus_write = 1'b1; bus_addr = 24'h00BEEF;
        tick();
        bus_enable = 1'b0;
        chk("midrst_busy", app_en, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_app_en", app_en, 1'b0);
        chk("midrst_wren", app_wdf_wren, 1'b0);
        chk("midrst_ready", bus_ready, 1'b1);

        // Randomised traffic checked against the transaction-level model.
        do_reset();
        m_out = 0; exp_rv = 1'b0; exp_rd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            init_calib_complete   = ($urandom_range(0, 15) != 0);
            bus_enable            = $urandom_range(0, 1);
            bus_write             = $urandom_range(0, 1);
            bus_addr              = AW'($urandom);
            bus_write_data        = {$urandom, $urandom, $urandom, $urandom};
            bus_write_byte_enable = 16'($urandom);
            app_rdy               = ($urandom_range(0, 3) != 0);
            app_wdf_rdy           = ($urandom_range(0, 3) != 0);
            app_rd_data_valid     = (m_out > 0) && ($urandom_range(0, 2) == 0);
            app_rd_data           = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);

            acc = init_calib_complete && (cmdq.size() == 0) && (wdfq.size() == 0) &&
                  (m_out < MAXO);
            chk("rnd_ready", bus_ready, acc);
            chk("rnd_app_en", app_en, cmdq.size() != 0);
            if (cmdq.size() != 0) begin
                chk("rnd_addr", app_addr, cmdq[0].addr);
                chk("rnd_cmd", app_cmd, cmdq[0].cmd);
            end
            chk("rnd_wren", app_wdf_wren, wdfq.size() != 0);
            chk("rnd_wend", app_wdf_end, wdfq.size() != 0);
            if (wdfq.size() != 0) begin
                chk("rnd_wdata", app_wdf_data, wdfq[0].data);
                chk("rnd_mask", app_wdf_mask, wdfq[0].mask);
            end
            chk("rnd_rvalid", bus_read_data_valid, exp_rv);
            if (exp_rv) chk("rnd_rdata", bus_read_data, exp_rd);
            chk("rnd_err", rd_overflow_err, 1'b0);

            // Events at the coming edge.
            acc    = acc && bus_enable;
            rd_acc = acc && !bus_write;
            if ((cmdq.size() != 0) && app_rdy) void'(cmdq.pop_front());
            if ((wdfq.size() != 0) && app_wdf_rdy) void'(wdfq.pop_front());
            if (acc) begin
                c.addr = AAW'(bus_addr) * 8;
                c.cmd  = bus_write ? 3'b000 : 3'b001;
                cmdq.push_back(c);
                if (bus_write) begin
                    w.data = bus_write_data;
                    w.mask = ~bus_write_byte_enable;
                    wdfq.push_back(w);
                end
            end
            if (rd_acc && !app_rd_data_valid) m_out++;
            else if (!rd_acc && app_rd_data_valid) m_out--;
            exp_rv = app_rd_data_valid;
            exp_rd = app_rd_data;
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
